// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and MEM exception report in,
// stall vector, flush and redirect PC out.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall merging, exception flush/redirect with
// programmable flush hold, and stall/flush performance counters.
module pipe_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE    = 32'h0000_000e
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus,
  output logic [31:0]   stall_cycles_o,
  output logic [15:0]   flush_count_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [3:0] HOLD_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  logic [0:0]  state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        accept_c;

  always_comb begin
    stall_c    = 6'b000000;
    flush_c    = 1'b0;
    new_pc_c   = 32'h0;
    accept_c   = 1'b0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pc_d       = pc_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          // MEM must be off the data bus before the exception can be taken.
          if (bus.excepttype_i != 32'h0 && !bus.stallreq_mem) begin
            accept_c = 1'b1;
            flush_c  = 1'b1;
            new_pc_c = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
            pc_d     = new_pc_c;
            if (FLUSH_CYCLES > 1) begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_INIT;
            end
          end else if (bus.stallreq_mem) begin
            stall_c = 6'b011111;
          end else if (bus.stallreq_ex) begin
            stall_c = 6'b001111;
          end else if (bus.stallreq_id) begin
            stall_c = 6'b000111;
          end else if (bus.stallreq_if) begin
            stall_c = 6'b000011;
          end
        end
        default: begin
          flush_c  = 1'b1;
          new_pc_c = pc_q;
          if (hold_cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      hold_cnt_q     <= 4'd0;
      pc_q           <= 32'h0;
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 16'h0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pc_q       <= pc_d;
      if (stall_c != 6'b000000 && stall_cycles_q != 32'hFFFF_FFFF) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (accept_c) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign bus.stall      = stall_c;
  assign bus.flush      = flush_c;
  assign bus.new_pc     = new_pc_c;
  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: three instances (FLUSH_CYCLES 1, 3, 4) share
// one directed stimulus stream; each step names which instance is checked.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if if1 ();
  pipe_ctrl_if if3 ();
  pipe_ctrl_if if4 ();
  logic [31:0] sc1, sc3, sc4;
  logic [15:0] fc1, fc3, fc4;

  pipe_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave),
                                      .stall_cycles_o(sc1), .flush_count_o(fc1));
  pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave),
                                      .stall_cycles_o(sc3), .flush_count_o(fc3));
  pipe_ctrl #(.FLUSH_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave),
                                      .stall_cycles_o(sc4), .flush_count_o(fc4));

  typedef struct {
    int          sel;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    bit          chk;
    logic [31:0] scnt;
    logic [15:0] fcnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   sel   = 1;

  task automatic set_in(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
    {if1.stallreq_mem, if1.stallreq_ex, if1.stallreq_id, if1.stallreq_if} = req;
    {if3.stallreq_mem, if3.stallreq_ex, if3.stallreq_id, if3.stallreq_if} = req;
    {if4.stallreq_mem, if4.stallreq_ex, if4.stallreq_id, if4.stallreq_if} = req;
    if1.excepttype_i = exc; if3.excepttype_i = exc; if4.excepttype_i = exc;
    if1.cp0_epc_i    = epc; if3.cp0_epc_i    = epc; if4.cp0_epc_i    = epc;
  endtask

  // req bits: {mem, ex, id, if}
  task automatic cyc(input logic r, input logic [3:0] req, input logic [31:0] exc,
                     input logic [31:0] epc, input logic [5:0] es, input logic ef,
                     input logic [31:0] ep, input bit chk, input logic [31:0] esc,
                     input logic [15:0] efc, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    set_in(req, exc, epc);
    e.sel = sel; e.stall = es; e.flush = ef; e.pc = ep;
    e.chk = chk; e.scnt = esc; e.fcnt = efc; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check32(input string nm, input string tag, input logic [31:0] act,
                         input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", tag, nm, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle is a transaction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] pc, scv;
      logic [15:0] fcv;
      e = exp_q.pop_front();
      case (e.sel)
        1:       begin st = if1.stall; fl = if1.flush; pc = if1.new_pc; scv = sc1; fcv = fc1; end
        3:       begin st = if3.stall; fl = if3.flush; pc = if3.new_pc; scv = sc3; fcv = fc3; end
        default: begin st = if4.stall; fl = if4.flush; pc = if4.new_pc; scv = sc4; fcv = fc4; end
      endcase
      $display("txn %s dut%0d stall=%b flush=%b new_pc=%h stall_cycles=%h flush_count=%h",
               e.tag, e.sel, st, fl, pc, scv, fcv);
      check32("stall", e.tag, {26'h0, st}, {26'h0, e.stall});
      check32("flush", e.tag, {31'h0, fl}, {31'h0, e.flush});
      check32("new_pc", e.tag, pc, e.pc);
      if (e.chk) begin
        check32("stall_cycles", e.tag, scv, e.scnt);
        check32("flush_count", e.tag, {16'h0, fcv}, {16'h0, e.fcnt});
      end
    end
  end

  localparam logic [3:0] R0 = 4'b0000, RIF = 4'b0001, RID = 4'b0010,
                         REX = 4'b0100, RMEM = 4'b1000, RIDEX = 4'b0110;
  localparam logic [31:0] EPC = 32'hBFC0_0100;

  initial begin
    set_in(R0, 32'h0, 32'h0);

    // FLUSH_CYCLES=1: stall encoding, counter, single-cycle flush, mem-blocked exception
    sel = 1;
    cyc(1, R0,    0, 0, 6'b000000, 0, 0, 0, 0, 0, "rst1");
    cyc(0, RIDEX, 0, 0, 6'b001111, 0, 0, 1, 0, 0, "idex0");
    cyc(0, RIDEX, 0, 0, 6'b001111, 0, 0, 1, 1, 0, "idex1");
    cyc(0, RIDEX, 0, 0, 6'b001111, 0, 0, 1, 2, 0, "idex2");
    cyc(0, R0,    0, 0, 6'b000000, 0, 0, 1, 3, 0, "idle0");
    cyc(0, RIF,   0, 0, 6'b000011, 0, 0, 1, 3, 0, "if");
    cyc(0, RID,   0, 0, 6'b000111, 0, 0, 1, 4, 0, "id");
    cyc(0, REX,   0, 0, 6'b001111, 0, 0, 1, 5, 0, "ex");
    cyc(0, RMEM,  0, 0, 6'b011111, 0, 0, 1, 6, 0, "mem");
    cyc(0, R0,    0, 0, 6'b000000, 0, 0, 1, 7, 0, "idle1");
    cyc(0, R0,    0, 0, 6'b000000, 0, 0, 1, 7, 0, "frozen");
    cyc(0, R0, 32'h8, 0, 6'b000000, 1, 32'h20, 1, 7, 0, "exc1");
    cyc(0, R0,    0, 0, 6'b000000, 0, 0, 1, 7, 1, "post1");
    for (int i = 0; i < 4; i++)
      cyc(0, RMEM, 32'h8, 0, 6'b011111, 0, 0, 1, 32'(7 + i), 1, "memblk");
    cyc(0, R0, 32'h8, 0, 6'b000000, 1, 32'h20, 1, 11, 1, "memrel");
    cyc(0, R0,    0, 0, 6'b000000, 0, 0, 1, 11, 2, "post2");

    // FLUSH_CYCLES=3: ERET redirect held three cycles, second exception ignored
    sel = 3;
    cyc(1, R0,       0,   0, 6'b000000, 0, 0,   0, 0, 0, "rst3");
    cyc(0, R0, 32'he, EPC,   6'b000000, 1, EPC, 1, 0, 0, "eret");
    cyc(0, RMEM, 32'h8, 0,   6'b000000, 1, EPC, 1, 0, 1, "hold1");
    cyc(0, R0,       0,   0, 6'b000000, 1, EPC, 1, 0, 1, "hold2");
    cyc(0, R0,       0,   0, 6'b000000, 0, 0,   1, 0, 1, "done3");

    // FLUSH_CYCLES=4: reset in second HOLD cycle, then stall counter saturation
    sel = 4;
    cyc(1, R0,       0, 0, 6'b000000, 0, 0,      0, 0, 0, "rst4");
    cyc(0, R0,   32'h8, 0, 6'b000000, 1, 32'h20, 1, 0, 0, "exc4");
    cyc(0, R0,       0, 0, 6'b000000, 1, 32'h20, 1, 0, 1, "hold4");
    cyc(1, R0,       0, 0, 6'b000000, 0, 0,      0, 0, 0, "rsthold");
    cyc(0, R0,       0, 0, 6'b000000, 0, 0,      1, 0, 0, "afterrst");
    cyc(0, RMEM,     0, 0, 6'b011111, 0, 0,      1, 32'hFFFF_FFFD, 0, "sat0");
    force dut4.stall_cycles_q = 32'hFFFF_FFFD;
    #1;
    release dut4.stall_cycles_q;
    cyc(0, RMEM,     0, 0, 6'b011111, 0, 0,      1, 32'hFFFF_FFFE, 0, "sat1");
    cyc(0, RMEM,     0, 0, 6'b011111, 0, 0,      1, 32'hFFFF_FFFF, 0, "sat2");
    cyc(0, RMEM,     0, 0, 6'b011111, 0, 0,      1, 32'hFFFF_FFFF, 0, "sat3");
    cyc(0, R0,       0, 0, 6'b000000, 0, 0,      1, 32'hFFFF_FFFF, 0, "sat4");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #6;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
